// File: rtl/rv_alu_pkg.sv
// Shared constants for the sequential RV ALU: FSM states, M-extension
// funct3 codes, base ALU control codes and XLEN-sliceable special values.
package rv_alu_pkg;

   // FSM states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // M-extension funct3
   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   // Base ALU control, low four bits of i_ctrl; bit 4 selects arithmetic shift
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_SHL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_EQ   = 4'd7;
   localparam logic [3:0] ALU_LTS  = 4'd8;
   localparam logic [3:0] ALU_LTU  = 4'd9;
   localparam logic [3:0] ALU_NEQ  = 4'd10;
   localparam logic [3:0] ALU_NLTS = 4'd11;
   localparam logic [3:0] ALU_NLTU = 4'd12;
   localparam int         ALU_ARITH_BIT = 4;

   // Special values at the widest legal XLEN; users slice to their width
   localparam logic [63:0] ALL_ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN_64      = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/rv_alu_mdu_iter.sv
// Iterative radix-2 multiply/divide core on unsigned magnitudes.
// Multiply: shift-add, product in {hi,lo}. Divide (RV_ALU_DIV_EN only):
// restoring shift-subtract, remainder in hi, quotient in lo.
// The final iteration is exposed combinationally (hi_nxt/lo_nxt with done)
// so the caller can register the result in the same edge.
module rv_alu_mdu_iter
   import rv_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
`ifdef RV_ALU_DIV_EN
   input  logic            is_div,
`endif
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);
   localparam int CW = $clog2(XLEN) + 1;

   logic            busy;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi, lo, opb;
   logic [XLEN:0]   sum;
`ifdef RV_ALU_DIV_EN
   logic            div_r;
`endif

   assign done = busy && (cnt == CW'(XLEN - 1));

   // one radix-2 step of the selected algorithm
   always_comb begin
      hi_nxt = hi;
      lo_nxt = lo;
      sum    = '0;
`ifdef RV_ALU_DIV_EN
      if (div_r) begin
         // bit XLEN of the difference is the borrow: set means "does not fit"
         sum = {hi, lo[XLEN-1]} - {1'b0, opb};
         if (!sum[XLEN]) begin
            hi_nxt = sum[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = {hi[XLEN-2:0], lo[XLEN-1]};
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else
`endif
      begin
         sum = {1'b0, hi} + ({(XLEN+1){lo[0]}} & {1'b0, opb});
         {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
      end
   end

   // operand load, iteration and counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         opb  <= '0;
`ifdef RV_ALU_DIV_EN
         div_r <= 1'b0;
`endif
      end else if (flush) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         hi   <= '0;
         lo   <= op_a;
         opb  <= op_b;
`ifdef RV_ALU_DIV_EN
         div_r <= is_div;
`endif
      end else if (busy) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt + CW'(1);
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end
      end
   end

endmodule

// File: rtl/rv_alu_seq.sv
// Multi-cycle RV integer ALU: base ops in one registered cycle, M-extension
// ops through the iterative core, valid/ready on both sides, flush abort.
// Optional divider: define RV_ALU_DIV_EN; without it DIV/DIVU/REM/REMU
// complete immediately with result 0 and o_illegal set.
module rv_alu_seq
   import rv_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic            i_m_op,
   input  logic [4:0]      i_ctrl,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_src_a,
   input  logic [XLEN-1:0] i_src_b,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_zero,
   output logic            o_illegal
);
   localparam int SHW = $clog2(XLEN);
`ifdef RV_ALU_DIV_EN
   localparam logic [XLEN-1:0] ONES = ALL_ONES_64[XLEN-1:0];
   localparam logic [XLEN-1:0] MIN  = MIN_64[63 -: XLEN];
`endif

   logic [1:0]        state;
   logic              accept, start, is_div_op, a_neg, b_neg, mdu_done, imm_ill;
   logic              op_hi, res_neg;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   mag_a, mag_b, base_res, sra_res, imm_res, fin_res, hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod;
`ifdef RV_ALU_DIV_EN
   logic              op_div, op_rem, rem_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   quo, rmd;
`endif

   assign o_ready   = (state == S_IDLE);
   assign accept    = i_valid & o_ready & ~i_flush;
   assign is_div_op = i_funct3[2];

   // a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
   assign a_neg = i_src_a[XLEN-1] & ((i_funct3 == F3_MULH) | (i_funct3 == F3_MULHSU) |
                                     (i_funct3 == F3_DIV)  | (i_funct3 == F3_REM));
   assign b_neg = i_src_b[XLEN-1] & ((i_funct3 == F3_MULH) | (i_funct3 == F3_DIV) |
                                     (i_funct3 == F3_REM));
   assign mag_a = a_neg ? -i_src_a : i_src_a;
   assign mag_b = b_neg ? -i_src_b : i_src_b;

   assign shamt   = i_src_b[SHW-1:0];
   assign sra_res = $signed(i_src_a) >>> shamt;

   // single-cycle base ALU
   always_comb begin
      base_res = '0;
      case (i_ctrl[3:0])
         ALU_ADD:  base_res = i_src_a + i_src_b;
         ALU_SUB:  base_res = i_src_a - i_src_b;
         ALU_XOR:  base_res = i_src_a ^ i_src_b;
         ALU_OR:   base_res = i_src_a | i_src_b;
         ALU_AND:  base_res = i_src_a & i_src_b;
         ALU_SHL:  base_res = i_src_a << shamt;
         ALU_SHR:  base_res = i_ctrl[ALU_ARITH_BIT] ? sra_res : (i_src_a >> shamt);
         ALU_EQ:   base_res[0] = (i_src_a == i_src_b);
         ALU_LTS:  base_res[0] = ($signed(i_src_a) < $signed(i_src_b));
         ALU_LTU:  base_res[0] = (i_src_a < i_src_b);
         ALU_NEQ:  base_res[0] = (i_src_a != i_src_b);
         ALU_NLTS: base_res[0] = ($signed(i_src_a) >= $signed(i_src_b));
         ALU_NLTU: base_res[0] = (i_src_a >= i_src_b);
         default:  base_res = '0;
      endcase
   end

`ifdef RV_ALU_DIV_EN
   // divide-by-zero and MIN/-1 are resolved at accept, never iterated
   assign div_zero = (i_src_b == '0);
   assign div_ovf  = ~i_funct3[0] & (i_src_a == MIN) & (i_src_b == ONES);
   assign start    = accept & i_m_op & ~(is_div_op & (div_zero | div_ovf));
`else
   assign start    = accept & i_m_op & ~is_div_op;
`endif

   // result for ops that finish at accept (base and special-case M ops)
   always_comb begin
      imm_res = base_res;
      imm_ill = 1'b0;
      if (i_m_op) begin
`ifdef RV_ALU_DIV_EN
         if (div_zero) imm_res = i_funct3[1] ? i_src_a : ONES;
         else          imm_res = i_funct3[1] ? '0 : MIN;
`else
         imm_res = '0;
         imm_ill = 1'b1;
`endif
      end
   end

   // sign correction of the iterative result
   assign prod = res_neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
`ifdef RV_ALU_DIV_EN
   assign quo     = res_neg ? -lo_nxt : lo_nxt;
   assign rmd     = rem_neg ? -hi_nxt : hi_nxt;
   assign fin_res = op_div ? (op_rem ? rmd : quo)
                           : (op_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
`else
   assign fin_res = op_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`endif

   rv_alu_mdu_iter #(.XLEN(XLEN)) u_iter (
      .clk    (i_clk),
      .rst    (i_reset),
      .flush  (i_flush),
      .start  (start),
`ifdef RV_ALU_DIV_EN
      .is_div (is_div_op),
`endif
      .op_a   (mag_a),
      .op_b   (mag_b),
      .done   (mdu_done),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   // handshake FSM and output registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= S_IDLE;
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_zero    <= 1'b1;
         o_illegal <= 1'b0;
         op_hi     <= 1'b0;
         res_neg   <= 1'b0;
`ifdef RV_ALU_DIV_EN
         op_div    <= 1'b0;
         op_rem    <= 1'b0;
         rem_neg   <= 1'b0;
`endif
      end else if (i_flush) begin
         state   <= S_IDLE;
         o_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_hi   <= (i_funct3 != F3_MUL);
               res_neg <= a_neg ^ b_neg;
`ifdef RV_ALU_DIV_EN
               op_div  <= is_div_op;
               op_rem  <= i_funct3[1];
               rem_neg <= a_neg;
`endif
               if (start) begin
                  state <= S_CALC;
               end else begin
                  state     <= S_DONE;
                  o_valid   <= 1'b1;
                  o_result  <= imm_res;
                  o_zero    <= (imm_res == '0);
                  o_illegal <= imm_ill;
               end
            end
            S_CALC: if (mdu_done) begin
               state     <= S_DONE;
               o_valid   <= 1'b1;
               o_result  <= fin_res;
               o_zero    <= (fin_res == '0);
               o_illegal <= 1'b0;
            end
            S_DONE: if (i_ready) begin
               state   <= S_IDLE;
               o_valid <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_alu_seq.sv
// Bench for rv_alu_seq (XLEN=32): directed test-plan vectors, backpressure,
// flush, async reset and a short random run against a behavioural model.
// Expectations follow the RV_ALU_DIV_EN setting of the build.
module tb_rv_alu_seq;
   import rv_alu_pkg::*;

   logic        i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_m_op = 1'b0;
   logic        i_flush = 1'b0, i_ready = 1'b0;
   logic [4:0]  i_ctrl = '0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_src_a = '0, i_src_b = '0;
   logic        o_ready, o_valid, o_zero, o_illegal;
   logic [31:0] o_result;

   typedef struct { logic [31:0] res; logic ill; int lat; } exp_t;
   typedef struct { logic [31:0] res; logic ill; logic zero; int lat; } obs_t;
   typedef struct { logic m; logic [4:0] c; logic [2:0] f; logic [31:0] a, b, r; logic ill; int lat; } vec_t;

   exp_t sb[$];
   int   total = 0, bad = 0;

   rv_alu_seq #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_m_op(i_m_op), .i_ctrl(i_ctrl), .i_funct3(i_funct3),
      .i_src_a(i_src_a), .i_src_b(i_src_b), .i_flush(i_flush),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_zero(o_zero), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // independent reference: native wide arithmetic
   function automatic exp_t model(logic m, logic [4:0] c, logic [2:0] f, logic [31:0] a, logic [31:0] b);
      exp_t e; longint sa, sb_; logic [63:0] p; logic [31:0] sra;
      sa = longint'($signed(a)); sb_ = longint'($signed(b));
      sra = $signed(a) >>> b[4:0];
      e.res = '0; e.ill = 1'b0; e.lat = 1; p = '0;
      if (!m) begin
         case (c[3:0])
            0: e.res = a + b;   1: e.res = a - b;   2: e.res = a ^ b;
            3: e.res = a | b;   4: e.res = a & b;   5: e.res = a << b[4:0];
            6: e.res = c[4] ? sra : (a >> b[4:0]);
            7: e.res = {31'b0, a == b};   8: e.res = {31'b0, sa < sb_};
            9: e.res = {31'b0, a < b};   10: e.res = {31'b0, a != b};
            11: e.res = {31'b0, sa >= sb_}; 12: e.res = {31'b0, a >= b};
            default: e.res = '0;
         endcase
      end else if (!f[2]) begin
         e.lat = 33;
         case (f[1:0])
            2'd0: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
            2'd1: begin p = sa * sb_; e.res = p[63:32]; end
            2'd2: begin p = sa * longint'({32'b0, b}); e.res = p[63:32]; end
            default: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
         endcase
      end else begin
`ifdef RV_ALU_DIV_EN
         if (b == 32'd0) e.res = f[1] ? a : 32'hFFFF_FFFF;
         else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = f[1] ? 32'd0 : a;
         else begin
            e.lat = 33;
            case (f[1:0])
               2'd0: e.res = 32'(sa / sb_);
               2'd1: e.res = a / b;
               2'd2: e.res = 32'(sa % sb_);
               default: e.res = a % b;
            endcase
         end
`else
         e.ill = 1'b1;
`endif
      end
      return e;
   endfunction

   task automatic drive(input logic m, input logic [4:0] c, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      i_valid = 1'b1; i_m_op = m; i_ctrl = c; i_funct3 = f; i_src_a = a; i_src_b = b;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic issue(input vec_t v);
      sb.push_back('{res: v.r, ill: v.ill, lat: v.lat});
      drive(v.m, v.c, v.f, v.a, v.b);
   endtask

   // bounded wait for o_valid; lat counts cycles after the accept edge
   task automatic wait_result(output obs_t o);
      int lat = 1;
      while (o_valid !== 1'b1 && lat < 100) begin @(posedge i_clk); #1; lat++; end
      o = '{res: o_result, ill: o_illegal, zero: o_zero, lat: lat};
   endtask

   task automatic consume();
      i_ready = 1'b1; @(posedge i_clk); #1; i_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      total++; if (o_result !== 32'd0 || o_zero !== 1'b1 || o_illegal !== 1'b0) begin
         bad++; $display("FAIL reset_outs got res=%h zero=%b ill=%b want 0/1/0", o_result, o_zero, o_illegal); end
   endtask

   task automatic run_list(input string name, input vec_t v[$]);
      obs_t o; exp_t e;
      foreach (v[i]) begin
         issue(v[i]);
         if (v[i].lat > 1) begin
            total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL %s_busy[%0d] got o_ready=%b want 0", name, i, o_ready); end
         end
         wait_result(o); e = sb.pop_front();
         total++;
         if (o.res !== e.res || o.ill !== e.ill || o.zero !== (e.res == 32'd0) || o.lat !== e.lat) begin
            bad++; $display("FAIL %s[%0d] got res=%h ill=%b zero=%b lat=%0d want res=%h ill=%b lat=%0d",
                            name, i, o.res, o.ill, o.zero, o.lat, e.res, e.ill, e.lat);
         end
         consume();
         total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL %s_ready[%0d] got=%b want=1", name, i, o_ready); end
      end
   endtask

   task automatic test_base();
      vec_t v[$];
      v.push_back('{0, {1'b0, ALU_ADD}, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1});
      v.push_back('{0, {1'b0, ALU_LTS}, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1});
      v.push_back('{0, {1'b1, ALU_SHR}, 3'd0, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1});
      v.push_back('{0, {1'b0, ALU_SHR}, 3'd0, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1});
      v.push_back('{0, {1'b0, ALU_SUB}, 3'd0, 32'd5, 32'd5, 32'd0, 0, 1});
      v.push_back('{0, {1'b0, ALU_LTU}, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1});
      v.push_back('{0, {1'b0, ALU_SHL}, 3'd0, 32'd1, 32'h25, 32'h20, 0, 1});
      run_list("base", v);
   endtask

   task automatic test_mul();
      vec_t v[$];
      v.push_back('{1, 5'd0, F3_MULH,   32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0, 33});
      v.push_back('{1, 5'd0, F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33});
      v.push_back('{1, 5'd0, F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 33});
      v.push_back('{1, 5'd0, F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33});
      run_list("mul", v);
   endtask

   task automatic test_div();
      vec_t v[$];
`ifdef RV_ALU_DIV_EN
      v.push_back('{1, 5'd0, F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 33});
      v.push_back('{1, 5'd0, F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 33});
      v.push_back('{1, 5'd0, F3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 1});
      v.push_back('{1, 5'd0, F3_REM,  32'd7, 32'd0, 32'd7, 0, 1});
      v.push_back('{1, 5'd0, F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1});
      v.push_back('{1, 5'd0, F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1});
      v.push_back('{1, 5'd0, F3_DIVU, 32'd100, 32'd7, 32'd14, 0, 33});
      v.push_back('{1, 5'd0, F3_REMU, 32'd100, 32'd7, 32'd2, 0, 33});
`else
      v.push_back('{1, 5'd0, F3_REMU, 32'd9, 32'd4, 32'd0, 1, 1});
      v.push_back('{1, 5'd0, F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 1, 1});
      v.push_back('{1, 5'd0, F3_MUL,  32'd9, 32'd4, 32'd36, 0, 33});
`endif
      run_list("div", v);
   endtask

   task automatic test_backpressure();
      obs_t o; exp_t e;
      issue('{1, 5'd0, F3_MUL, 32'd3, 32'd5, 32'd15, 0, 33});
      wait_result(o); e = sb.pop_front();
      total++; if (o.res !== e.res || o.lat !== e.lat) begin
         bad++; $display("FAIL bp_result got res=%h lat=%0d want res=%h lat=%0d", o.res, o.lat, e.res, e.lat); end
      for (int k = 0; k < 5; k++) begin
         @(posedge i_clk); #1;
         total++; if (o_valid !== 1'b1 || o_result !== 32'd15 || o_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold[%0d] got valid=%b res=%h ready=%b want 1/0000000f/0", k, o_valid, o_result, o_ready); end
      end
      consume();
      total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", o_ready, o_valid); end
   endtask

   task automatic test_flush();
      int seen = 0;
      obs_t o; exp_t e;
`ifdef RV_ALU_DIV_EN
      drive(1'b1, 5'd0, F3_DIV, 32'd100, 32'd7);
`else
      drive(1'b1, 5'd0, F3_MULHU, 32'd100, 32'd7);
`endif
      repeat (9) begin @(posedge i_clk); #1; end
      // flush with a competing request in the same cycle: neither may survive
      i_flush = 1'b1;
      i_valid = 1'b1; i_m_op = 1'b0; i_ctrl = {1'b0, ALU_ADD}; i_src_a = 32'd1; i_src_b = 32'd1;
      @(posedge i_clk); #1;
      i_flush = 1'b0; i_valid = 1'b0;
      total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         bad++; $display("FAIL flush_idle got ready=%b valid=%b want 1/0", o_ready, o_valid); end
      for (int k = 0; k < 40; k++) begin
         if (o_valid === 1'b1) seen++;
         @(posedge i_clk); #1;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end
      issue('{0, {1'b0, ALU_ADD}, 3'd0, 32'd2, 32'd3, 32'd5, 0, 1});
      wait_result(o); e = sb.pop_front();
      total++; if (o.res !== e.res || o.lat !== e.lat) begin
         bad++; $display("FAIL flush_after got res=%h lat=%0d want res=%h lat=%0d", o.res, o.lat, e.res, e.lat); end
      consume();
   endtask

   task automatic test_async_reset();
      obs_t o; exp_t e;
      drive(1'b1, 5'd0, F3_MUL, 32'd11, 32'd13);
      repeat (5) begin @(posedge i_clk); #1; end
      #2 i_reset = 1'b1;
      #1;
      total++; if (o_valid !== 1'b0 || o_result !== 32'd0 || o_zero !== 1'b1 || o_illegal !== 1'b0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL async_reset got valid=%b res=%h zero=%b ill=%b ready=%b want 0/0/1/0/1",
                         o_valid, o_result, o_zero, o_illegal, o_ready); end
      #2 i_reset = 1'b0;
      @(posedge i_clk); #1;
      issue('{1, 5'd0, F3_MUL, 32'd6, 32'd7, 32'd42, 0, 33});
      wait_result(o); e = sb.pop_front();
      total++; if (o.res !== e.res || o.lat !== e.lat) begin
         bad++; $display("FAIL reset_recover got res=%h lat=%0d want res=%h lat=%0d", o.res, o.lat, e.res, e.lat); end
      consume();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      vec_t v[$];
      exp_t e;
      vec_t x;
      for (int k = 0; k < 24; k++) begin
         x.m = 1'($urandom_range(0, 1));
         x.c[3:0] = 4'($urandom_range(0, 12));
         x.c[4] = (x.c[3:0] == ALU_SHR) ? 1'($urandom_range(0, 1)) : 1'b0;
         x.f = 3'($urandom_range(0, 7));
         x.a = pick(); x.b = pick();
         e = model(x.m, x.c, x.f, x.a, x.b);
         x.r = e.res; x.ill = e.ill; x.lat = e.lat;
         v.push_back(x);
      end
      run_list("rand", v);
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(posedge i_clk); #1;
      test_reset();
      test_base();
      test_mul();
      test_div();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_alu_seq.md
# rv_alu_seq

Parametrised, multi-cycle successor of the single-cycle RV integer ALU for the execute stage. It computes the base integer ops (add/sub/logic/shift/compare, using the shared ALU control encoding) with a one-cycle registered result. It also computes the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with an iterative radix-2 datapath. Both sides use valid/ready handshakes, so the pipeline can stall on long ops. A flush input lets the hazard unit abort an in-flight op.

## Interface
- XLEN, 32, operand/result width; legal values 32 and 64
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request (state IDLE)
- i_m_op  in  1  1 = M-extension op (use i_funct3), 0 = base op (use i_ctrl)
- i_ctrl  in  5  base ALU control, shared encoding (ADD/SUB/XOR/OR/AND/SHL/SHR, CMP_EQ/LTS/LTU/NEQ/NLTS/NLTU; bit4 = arithmetic shift)
- i_funct3  in  3  M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_src_a, i_src_b  in  XLEN  operands
- i_flush  in  1  abort current op, discard result
- o_valid  out  1  result valid, held until accepted
- i_ready  in  1  consumer accepts result
- o_result  out  XLEN  result (compares: zero-extended 0/1)
- o_zero  out  1  o_result == 0
- o_illegal  out  1  qualified by o_valid; op not supported in this build

## Operation
- States: IDLE, CALC, DONE. Request accepted on i_valid & o_ready.
- Base op: result computed combinationally and registered at accept. IDLE -> DONE. Shift amount is i_src_b[$clog2(XLEN)-1:0].
- MUL*: operands latched with sign handling (MULH both signed, MULHSU a signed / b unsigned, MULHU unsigned). 2·XLEN-bit product. MUL returns low half, others return high half. IDLE -> CALC, XLEN shift-add iterations, then -> DONE.
- DIV*/REM*: restoring shift-subtract on operand magnitudes, with final sign correction (quotient negative iff signs differ; remainder takes the dividend's sign).
- Divide by zero: quotient all ones, remainder = dividend. Completes IDLE -> DONE without CALC.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. Completes IDLE -> DONE without CALC.
- DONE: o_valid=1. On i_ready -> IDLE. Output registers are stable while o_valid & !i_ready.
- i_flush in any state: -> IDLE next cycle, o_valid deasserted, and no new request is accepted that cycle.
- Reset: state IDLE; o_valid=0, o_result=0, o_zero=1, o_illegal=0, iteration counter 0. Reset mid-op discards all work.

## Timing
- Request accepted at edge N.
- Base op, div-by-zero and overflow cases: o_valid from N+1.
- MUL*/DIV*/REM*: o_valid from N+XLEN+1.
- o_ready is 0 from N+1 until the cycle after the result is consumed. There is no back-to-back accept in the same cycle as DONE -> IDLE.
- Throughput is at most one op per 2 cycles for base ops.
- o_ready is combinational from state only. There is no combinational path from i_valid to o_ready, or from i_ready to o_valid.

## Configuration
- RV_ALU_DIV_EN defined: divider datapath built; DIV/DIVU/REM/REMU behave as above.
- RV_ALU_DIV_EN undefined: no divider logic. Div/rem ops complete at N+1 with o_result=0 and o_illegal=1. MUL* is unaffected.

## Structure
- Package rv_alu_pkg holds:
  - state enum (IDLE/CALC/DONE)
  - M funct3 localparams
  - base-op control codes
  - special-case constants (all-ones, MIN for XLEN)
- Sub-module rv_alu_mdu_iter: the shared shift-add/shift-subtract iterative datapath and counter, with start/done handshake to the top FSM. The top holds operand sign prep, base ops, result registers and the handshake.

## Test plan
- Base ADD a=0x7FFFFFFF, b=1 -> o_result 0x80000000 at N+1; CMP_LTS a=-1, b=1 -> 1; SHR arithmetic 0x80000000>>4 -> 0xF8000000.
- MULH a=-2, b=3 (XLEN=32) -> 0xFFFFFFFF at N+33; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIV a=-7, b=2 -> -3; REM -> -1; DIVU 7/0 -> 0xFFFFFFFF at N+1; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- Backpressure: hold i_ready=0 for 5 cycles after MUL completes -> o_valid and o_result stable, o_ready=0. Release -> o_ready=1 next cycle.
- i_flush at N+10 of a DIV -> o_valid never asserts; o_ready=1 at N+11; a subsequent ADD completes normally. Async i_reset mid-MUL -> all outputs at reset values immediately.
- Build without RV_ALU_DIV_EN: REMU 9/4 -> o_result 0, o_illegal=1 at N+1; MUL unaffected.
